// File: rtl/upper_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : upper_uart_tx
// Brief   : Byte FIFO feeding a UART 8N1 transmitter (LSB first, back-to-back)
// Rev     : 1.0  initial release
// ============================================================================
module upper_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]    BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [BW-1:0]        baud_cnt, baud_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [7:0]           shift, shift_n;
  logic                 tx_n;
  logic                 baud_last;
  logic                 push, pop;
  logic                 fifo_nonempty;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;

  assign in_ready      = (fifo_count != FULL_COUNT);
  assign fifo_nonempty = (fifo_count != '0);
  assign push          = in_valid & in_ready;
  assign baud_last     = (baud_cnt == BAUD_LAST);
  assign busy          = (state != IDLE) | fifo_nonempty;

  // Storage has no reset; validity is tracked by the count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    pop        = 1'b0;
    tx_n       = 1'b1;

    if (state != IDLE) begin
      baud_cnt_n = baud_last ? '0 : baud_cnt + BW'(1);
    end

    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_last) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Reload straight from the stop bit so queued bytes leave with no idle gap.
        if (baud_last) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule
`default_nettype wire
